// File: rtl/aes128_encrypt_iterative_pkg.sv
// rtl/aes128_encrypt_iterative_pkg.sv - AES-128 constants, round tables and GF(2^8) helpers
package aes128_encrypt_iterative_pkg;

    localparam int AES_NR = 10;

    // Round constants indexed by round number; slot 0 and slots above 10 are unused.
    localparam logic [15:0][7:0] RCON = {
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h36, 8'h1b, 8'h80,
        8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00
    };

    // Forward ShiftRows: output byte i is taken from input byte SHIFT_ROWS_IDX[i].
    localparam logic [15:0][3:0] SHIFT_ROWS_IDX = {
        4'd11, 4'd6, 4'd1, 4'd12, 4'd7, 4'd2, 4'd13, 4'd8,
        4'd3, 4'd14, 4'd9, 4'd4, 4'd15, 4'd10, 4'd5, 4'd0
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } fsm_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Column bytes are row 0 in the top byte down to row 3 in the bottom byte.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // RotWord wiring ahead of the four key-schedule S-boxes.
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes128_encrypt_iterative_if.sv
// rtl/aes128_encrypt_iterative_if.sv - block-in / ciphertext-out handshake bundle
interface aes128_encrypt_iterative_if;
    // 128-bit buses carry byte 0 in the most-significant byte, byte 15 in the least.
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;
    logic         busy;

    modport master (
        output in_valid, plaintext, key, out_ready,
        input  in_ready, out_valid, ciphertext, busy
    );

    modport slave (
        input  in_valid, plaintext, key, out_ready,
        output in_ready, out_valid, ciphertext, busy
    );
endinterface

// File: rtl/aes128_encrypt_iterative_sbox.sv
// rtl/aes128_encrypt_iterative_sbox.sv - combinational forward AES S-box
module aes128_encrypt_iterative_sbox (
    input  logic [7:0] x,
    output logic [7:0] y
);
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign y = SBOX[x];
endmodule

// File: rtl/aes128_encrypt_iterative.sv
// rtl/aes128_encrypt_iterative.sv - iterative AES-128 encrypt core, one round per clock
module aes128_encrypt_iterative
    import aes128_encrypt_iterative_pkg::*;
#(
    parameter int NR          = AES_NR,
    parameter bit ZERO_ON_POP = 1'b1
) (
    input  logic clk,
    input  logic rst,
    aes128_encrypt_iterative_if.slave bus
);
    localparam logic [3:0] LAST_ROUND = 4'(NR);

    generate
        if (NR != AES_NR) begin : g_bad_nr
            $error("aes128_encrypt_iterative: only NR=10 is supported");
        end
    endgenerate

    fsm_t         fsm_q, fsm_d;
    logic [127:0] state_q, rkey_q, ct_q;
    logic [3:0]   round_q;
    logic         accept, last_round, pop;

    logic [31:0]  rot_w3, sub_w3, key_t;
    logic [127:0] next_key, shifted, mixed, next_state;
    logic [7:0]   sb_bytes [16];

    assign rot_w3 = rot_word(rkey_q[31:0]);

    for (genvar k = 0; k < 4; k++) begin : g_key_sbox
        aes128_encrypt_iterative_sbox u_sbox (.x(rot_w3[31-8*k -: 8]), .y(sub_w3[31-8*k -: 8]));
    end

    for (genvar i = 0; i < 16; i++) begin : g_state_sbox
        aes128_encrypt_iterative_sbox u_sbox (.x(state_q[127-8*i -: 8]), .y(sb_bytes[i]));
    end

    // Expand the next round key and apply one full round (MixColumns skipped on the last).
    always_comb begin
        key_t             = sub_w3 ^ {RCON[round_q], 24'h0};
        next_key[127:96]  = rkey_q[127:96] ^ key_t;
        next_key[95:64]   = rkey_q[95:64]  ^ next_key[127:96];
        next_key[63:32]   = rkey_q[63:32]  ^ next_key[95:64];
        next_key[31:0]    = rkey_q[31:0]   ^ next_key[63:32];
        shifted = '0;
        mixed   = '0;
        for (int i = 0; i < 16; i++) begin
            shifted[127-8*i -: 8] = sb_bytes[SHIFT_ROWS_IDX[i]];
        end
        for (int c = 0; c < 4; c++) begin
            mixed[127-32*c -: 32] = mix_column(shifted[127-32*c -: 32]);
        end
        next_state = ((round_q == LAST_ROUND) ? shifted : mixed) ^ next_key;
    end

    // Next-state decode and handshake outputs; in_ready only rises once IDLE is registered.
    always_comb begin
        fsm_d         = fsm_q;
        accept        = 1'b0;
        last_round    = 1'b0;
        pop           = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;
        case (fsm_q)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
                if (bus.in_valid) begin
                    accept = 1'b1;
                    fsm_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (round_q == LAST_ROUND) begin
                    last_round = 1'b1;
                    fsm_d      = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    pop   = 1'b1;
                    fsm_d = ST_IDLE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    assign bus.ciphertext = ct_q;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q <= ST_IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // Round datapath and ciphertext register; reset drops any block in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '0;
            rkey_q  <= '0;
            ct_q    <= '0;
            round_q <= '0;
        end else begin
            if (accept) begin
                state_q <= bus.plaintext ^ bus.key;
                rkey_q  <= bus.key;
                round_q <= 4'd1;
            end else if (fsm_q == ST_RUN) begin
                state_q <= next_state;
                rkey_q  <= next_key;
                round_q <= round_q + 4'd1;
            end
            if (last_round) begin
                ct_q <= next_state;
            end else if (pop && ZERO_ON_POP) begin
                ct_q <= '0;
            end
        end
    end

    // The exit decode must catch round NR; anything above it while running is a lost exit.
    assert property (@(posedge clk) disable iff (rst) (fsm_q == ST_RUN) |-> (round_q <= LAST_ROUND));

endmodule

// File: tb/tb_aes128_encrypt_iterative.sv
// tb/tb_aes128_encrypt_iterative.sv - scoreboard bench for the iterative AES-128 encrypt core
module tb_aes128_encrypt_iterative;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_Z = 128'h0;
    localparam logic [127:0] PT_Z  = 128'h0;
    localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   pops = 0;
    int   acc_cyc = 0;
    logic [127:0] exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes128_encrypt_iterative_if bus();

    aes128_encrypt_iterative #(.NR(10), .ZERO_ON_POP(1'b1)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every output handshake pops one expected ciphertext.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            pops++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h expected no output", bus.ciphertext);
            end else begin
                check("ciphertext", bus.ciphertext, exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [127:0] pt, input logic [127:0] k,
                        input logic [127:0] ct, input bit keep_valid);
        int n = 0;
        bus.plaintext = pt;
        bus.key       = k;
        bus.in_valid  = 1'b1;
        while (!bus.in_ready && n < 40) begin
            tick();
            n++;
        end
        check("accept_ready", 128'(bus.in_ready), 128'd1);
        exp_q.push_back(ct);
        tick();
        acc_cyc = cyc;
        if (!keep_valid) bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 30) begin
            tick();
            lat++;
        end
        check("out_valid_seen", 128'(bus.out_valid), 128'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int acc [3];
        logic saw;
        logic [127:0] bb_pt [3];
        logic [127:0] bb_key [3];
        logic [127:0] bb_ct [3];
        bb_pt  = '{PT_B, PT_C, PT_Z};
        bb_key = '{KEY_B, KEY_C, KEY_Z};
        bb_ct  = '{CT_B, CT_C, CT_Z};

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.plaintext = '0;
        bus.key       = '0;
        repeat (3) tick();
        check("rst_in_ready", 128'(bus.in_ready), 128'd1);
        check("rst_out_valid", 128'(bus.out_valid), 128'd0);
        check("rst_busy", 128'(bus.busy), 128'd0);
        check("rst_ciphertext", bus.ciphertext, 128'd0);
        rst = 1'b0;
        tick();

        // App B with inputs changed after accept, then backpressure in DONE.
        send(PT_B, KEY_B, CT_B, 1'b0);
        bus.plaintext = PT_C;
        bus.key       = KEY_C;
        bus.in_valid  = 1'b1;
        check("run_in_ready", 128'(bus.in_ready), 128'd0);
        check("run_busy", 128'(bus.busy), 128'd1);
        wait_out(lat);
        check("latency_b", 128'(lat), 128'd10);
        bus.in_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            check("bp_out_valid", 128'(bus.out_valid), 128'd1);
            check("bp_in_ready", 128'(bus.in_ready), 128'd0);
            check("bp_ciphertext", bus.ciphertext, CT_B);
            tick();
        end
        bus.out_ready = 1'b1;
        check("pop_cycle_in_ready", 128'(bus.in_ready), 128'd0);
        tick();
        check("post_pop_in_ready", 128'(bus.in_ready), 128'd1);
        check("post_pop_out_valid", 128'(bus.out_valid), 128'd0);
        check("post_pop_busy", 128'(bus.busy), 128'd0);
        check("post_pop_zeroed", bus.ciphertext, 128'd0);

        // Reset at round 5 aborts the block; the next block is still correct.
        send(PT_B, KEY_B, CT_B, 1'b0);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check("abort_out_valid", 128'(bus.out_valid), 128'd0);
        check("abort_in_ready", 128'(bus.in_ready), 128'd1);
        check("abort_ciphertext", bus.ciphertext, 128'd0);
        check("abort_busy", 128'(bus.busy), 128'd0);
        saw = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (bus.out_valid) saw = 1'b1;
            tick();
        end
        check("abort_no_partial", 128'(saw), 128'd0);
        send(PT_C, KEY_C, CT_C, 1'b0);
        wait_out(lat);
        check("latency_c", 128'(lat), 128'd10);
        tick();

        // Back-to-back: in_valid and out_ready held high across three blocks.
        for (int b = 0; b < 3; b++) begin
            send(bb_pt[b], bb_key[b], bb_ct[b], 1'b1);
            acc[b] = acc_cyc;
        end
        bus.in_valid = 1'b0;
        check("b2b_spacing_01", 128'(acc[1] - acc[0]), 128'd12);
        check("b2b_spacing_12", 128'(acc[2] - acc[1]), 128'd12);
        lat = 0;
        while (exp_q.size() != 0 && lat < 40) begin
            tick();
            lat++;
        end
        check("drain_pending", 128'(exp_q.size()), 128'd0);
        tick();
        check("total_outputs", 128'(pops), 128'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
